fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//  Receiver-side reader for the dual-clock fifo: drains words via the used/acknowledge read port
//  and re-presents them as a registered valid/ready stream in the receiver domain.
//  Drains in bursts gated by a fill threshold or a flush request.
//  Checks that drained words form a +1 sequence modulo 2**DATA_WIDTH, for link bring-up and soak tests.
// PARAMETERS
//  DATA_WIDTH      16   word width; must match the fifo instance
//  POINTER_WIDTH   8    fifo pointer width; data_out_used width
//  BURST_THRESHOLD 16   minimum data_out_used that starts a drain burst; 1..2**POINTER_WIDTH-1
//  CHECK_SEQUENCE  1    1 = sequence checker active; 0 = error outputs tied 0
// PORTS
//  receiver_clock        in   1              sole clock (fifo receiver clock)
//  receiver_reset_n      in   1              asynchronous, active-low reset
//  data_out_used         in   POINTER_WIDTH  fifo occupancy; drops by 1 the cycle after each acknowledge
//  data_out              in   DATA_WIDTH     fifo head word; valid while data_out_used > 0
//  data_out_acknowledge  out  1              pops fifo head at the rising edge
//  flush                 in   1              level; forces draining regardless of threshold
//  stream_valid          out  1              stream_data holds a word
//  stream_ready          in   1              downstream accepts the word at the edge when valid
//  stream_data           out  DATA_WIDTH     buffered head word
//  word_count            out  32             wrapping count of words popped
//  sequence_error        out  1              sticky; a popped word was not previous+1
//  error_count           out  16             saturating count of sequence mismatches
// BEHAVIOUR
//  Reset (async assert): state IDLE; buffer empty; stream_valid=0; stream_data=0.
//   word_count=0; sequence_error=0; error_count=0; checker un-primed.
//   data_out_acknowledge=0 immediately: it is combinational from registered state.
//   Release takes effect at the next rising edge.
//  FSM (registered), typedef reader_state_t {IDLE, DRAIN}:
//   IDLE -> DRAIN when data_out_used >= BURST_THRESHOLD or flush.
//   DRAIN -> IDLE when data_out_used == 0 and !flush; otherwise stay in DRAIN.
//   Threshold is sampled only in IDLE; a burst continues below threshold until the fifo is empty.
//  data_out_acknowledge = (state==DRAIN) && (data_out_used != 0) && (buffer_count < 2).
//   It never asserts when the fifo is empty. Underflow is impossible by construction.
//  Output buffer: 2-entry in-order buffer.
//   Push = acknowledge (captures data_out). Pop = stream_valid && stream_ready.
//   stream_valid = buffer_count != 0. stream_data = oldest entry; holds stable while valid && !ready.
//   Latency: word popped at edge t is on stream_data from edge t if buffer was empty.
//    With back-pressure it waits behind older entries.
//   Push and pop in the same cycle: count unchanged, order preserved.
//   Full (2 entries): acknowledge deasserts; no word is ever dropped or duplicated.
//   Sustained throughput: 1 word/cycle with stream_ready held high.
//  word_count increments by 1 on every acknowledge edge; wraps 2**32-1 -> 0.
//  Sequence checker (CHECK_SEQUENCE=1), on each acknowledge:
//   Primed and data_out != last+1 (DATA_WIDTH-bit wrap; all-ones -> 0 is legal):
//    sequence_error <= 1; error_count += 1, saturating at 16'hFFFF.
//   In all cases last <= data_out; primed <= 1. The first word after reset is never an error.
//  flush deasserting mid-burst does not stop the burst.
//  Reset mid-burst discards buffered words; unpopped fifo words remain in the fifo.
// STRUCTURE
//  fifo_reader_pkg: reader_state_t; WORD_COUNT_WIDTH=32; ERROR_COUNT_WIDTH=16.
//  Sub-module stream_skid_buffer #(DATA_WIDTH): 2-entry buffer.
//   Ports: push, push_data, pop, count, head; same clock and reset.
//  Top level holds the FSM, acknowledge logic, counters and checker.
// TESTING
//  1 Threshold: used=15 held, flush=0 -> no acknowledge.
//     used 15->16 -> acknowledge next cycle; 16 words drained; returns to IDLE at used=0.
//  2 Flush: used=3, flush pulse 1 cycle -> exactly 3 pops; stream carries 3 words in order; IDLE after.
//  3 Back-pressure: stream_ready=0, used=40, threshold met -> exactly 2 pops, then acknowledge low.
//     Data held stable. Raising ready -> 1 word/cycle, order intact.
//  4 Wrap: feed 16'hFFFE, FFFF, 0000, 0001 -> sequence_error stays 0; word_count=4.
//  5 Gap: feed 5, 6, 8 -> sequence_error=1 after the third pop; error_count=1.
//     Subsequent 9 raises no new error.
//  6 Reset mid-burst: assert receiver_reset_n=0 with 2 words buffered -> same instant:
//     acknowledge=0, stream_valid=0. All counters 0. First word after release is not an error.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_reader_pkg: shared types and widths for the fifo stream reader.
package fifo_reader_pkg;
  typedef enum logic {IDLE, DRAIN} reader_state_t;
  localparam int WORD_COUNT_WIDTH  = 32;
  localparam int ERROR_COUNT_WIDTH = 16;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: fifo read port plus outgoing valid/ready stream.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int POINTER_WIDTH = 8
);
  logic [POINTER_WIDTH-1:0] data_out_used;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     data_out_acknowledge;
  logic                     stream_valid;
  logic                     stream_ready;
  logic [DATA_WIDTH-1:0]    stream_data;
  modport master (
    input  data_out_used, data_out, stream_ready,
    output data_out_acknowledge, stream_valid, stream_data
  );
  modport slave (
    output data_out_used, data_out, stream_ready,
    input  data_out_acknowledge, stream_valid, stream_data
  );
endinterface

// File: rtl/fifo_stream_reader_skid.sv
// stream_skid_buffer: 2-entry in-order buffer; caller never pushes when full.
module stream_skid_buffer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_rd;
  logic [1:0]            r_count;
  logic                  w_wr;
  // write slot is the one after the oldest entry when one word is held
  assign w_wr  = r_rd ^ r_count[0];
  assign count = r_count;
  assign head  = r_mem[r_rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) r_mem[w_wr] <= push_data;
      if (pop) r_rd <= ~r_rd;
      r_count <= r_count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: burst-drains the fifo read port into a registered stream
// and checks that drained words form a +1 sequence.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int POINTER_WIDTH   = 8,
  parameter int BURST_THRESHOLD = 16,
  parameter bit CHECK_SEQUENCE  = 1
) (
  input  logic                         receiver_clock,
  input  logic                         receiver_reset_n,
  fifo_stream_reader_if.master         bus,
  input  logic                         flush,
  output logic [WORD_COUNT_WIDTH-1:0]  word_count,
  output logic                         sequence_error,
  output logic [ERROR_COUNT_WIDTH-1:0] error_count
);
  reader_state_t                r_state;
  reader_state_t                w_next;
  logic                         w_ack;
  logic                         w_pop;
  logic                         w_empty;
  logic [1:0]                   w_count;
  logic [WORD_COUNT_WIDTH-1:0]  r_word_count;
  assign w_empty = bus.data_out_used == '0;
  assign w_pop   = (w_count != 2'd0) && bus.stream_ready;
  // threshold only matters from IDLE; once draining, run until the fifo is empty
  always_comb begin
    w_next = r_state;
    w_ack  = 1'b0;
    w_next = (r_state == IDLE)
           ? ((bus.data_out_used >= POINTER_WIDTH'(BURST_THRESHOLD) || flush) ? DRAIN : IDLE)
           : ((w_empty && !flush) ? IDLE : DRAIN);
    w_ack  = (r_state == DRAIN) && !w_empty && (w_count < 2'd2);
  end
  always_ff @(posedge receiver_clock or negedge receiver_reset_n) begin
    if (!receiver_reset_n) begin
      r_state      <= IDLE;
      r_word_count <= '0;
    end else begin
      r_state      <= w_next;
      r_word_count <= r_word_count + WORD_COUNT_WIDTH'(w_ack);
    end
  end
  stream_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (receiver_clock),
    .rst_n     (receiver_reset_n),
    .push      (w_ack),
    .push_data (bus.data_out),
    .pop       (w_pop),
    .count     (w_count),
    .head      (bus.stream_data)
  );
  assign bus.data_out_acknowledge = w_ack;
  assign bus.stream_valid         = w_count != 2'd0;
  assign word_count               = r_word_count;
  if (CHECK_SEQUENCE) begin : g_chk
    logic                         r_primed;
    logic [DATA_WIDTH-1:0]        r_last;
    logic                         r_err;
    logic [ERROR_COUNT_WIDTH-1:0] r_err_count;
    logic [DATA_WIDTH-1:0]        w_expect;
    assign w_expect = r_last + DATA_WIDTH'(1);
    always_ff @(posedge receiver_clock or negedge receiver_reset_n) begin
      if (!receiver_reset_n) begin
        r_primed    <= 1'b0;
        r_last      <= '0;
        r_err       <= 1'b0;
        r_err_count <= '0;
      end else if (w_ack) begin
        r_last   <= bus.data_out;
        r_primed <= 1'b1;
        if (r_primed && bus.data_out != w_expect) begin
          r_err       <= 1'b1;
          r_err_count <= (&r_err_count) ? r_err_count : r_err_count + ERROR_COUNT_WIDTH'(1);
        end
      end
    end
    assign sequence_error = r_err;
    assign error_count    = r_err_count;
  end else begin : g_nochk
    assign sequence_error = 1'b0;
    assign error_count    = '0;
  end
endmodule
